// File: rtl/unified_mem_arbiter_if.sv
// Signal bundle between the pipeline/backend memory and the unified memory arbiter.
// The master view is the arbiter itself; the slave view is the pipeline plus backend.
interface unified_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              dm_read;
    logic              dm_write;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] if_instr;
    logic              if_done;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_done;
    logic              stall_if;
    logic              stall_mem;
    logic              bus_err;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  if_req, if_addr, dm_read, dm_write, dm_addr, dm_wdata, mem_ready, mem_rdata,
        output if_instr, if_done, dm_rdata, dm_done, stall_if, stall_mem, bus_err,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output if_req, if_addr, dm_read, dm_write, dm_addr, dm_wdata, mem_ready, mem_rdata,
        input  if_instr, if_done, dm_rdata, dm_done, stall_if, stall_mem, bus_err,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and data access,
// with data priority, pipeline stall generation and a watchdog for hung accesses.
module unified_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input logic                   clk,
    input logic                   reset,
    unified_mem_arbiter_if.master bus
);
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        DATA_BUSY  = 3'd1,
        FETCH_BUSY = 3'd2,
        DATA_DONE  = 3'd3,
        FETCH_DONE = 3'd4
    } state_t;

    localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

    state_t            state_r,    state_nx_s;
    logic              mem_req_r,  mem_req_nx_s;
    logic              mem_we_r,   mem_we_nx_s;
    logic [ADDR_W-1:0] mem_addr_r, mem_addr_nx_s;
    logic [DATA_W-1:0] mem_wdata_r, mem_wdata_nx_s;
    logic [DATA_W-1:0] if_instr_r, if_instr_nx_s;
    logic [DATA_W-1:0] dm_rdata_r, dm_rdata_nx_s;
    logic              if_done_r,  if_done_nx_s;
    logic              dm_done_r,  dm_done_nx_s;
    logic              bus_err_r,  bus_err_nx_s;
    logic [15:0]       wdog_r,     wdog_nx_s;
    logic              wdog_expire_s;
    logic              stall_mem_s;
    logic              stall_if_s;

    // Watchdog fires on the BUSY cycle that would make the count reach TIMEOUT.
    always_comb begin
        if (TIMEOUT_C != 16'd0) begin
            wdog_expire_s = ((wdog_r + 16'd1) == TIMEOUT_C);
        end else begin
            wdog_expire_s = 1'b0;
        end
    end

    // Next-state and next-output logic for the access FSM.
    always_comb begin
        state_nx_s     = state_r;
        mem_req_nx_s   = mem_req_r;
        mem_we_nx_s    = mem_we_r;
        mem_addr_nx_s  = mem_addr_r;
        mem_wdata_nx_s = mem_wdata_r;
        if_instr_nx_s  = if_instr_r;
        dm_rdata_nx_s  = dm_rdata_r;
        if_done_nx_s   = 1'b0;
        dm_done_nx_s   = 1'b0;
        bus_err_nx_s   = bus_err_r;
        wdog_nx_s      = wdog_r;
        case (state_r)
            IDLE: begin
                if (bus.dm_read | bus.dm_write) begin
                    mem_req_nx_s   = 1'b1;
                    mem_we_nx_s    = bus.dm_write;
                    mem_addr_nx_s  = bus.dm_addr;
                    mem_wdata_nx_s = bus.dm_wdata;
                    wdog_nx_s      = 16'd0;
                    state_nx_s     = DATA_BUSY;
                end else if (bus.if_req) begin
                    mem_req_nx_s   = 1'b1;
                    mem_we_nx_s    = 1'b0;
                    mem_addr_nx_s  = bus.if_addr;
                    wdog_nx_s      = 16'd0;
                    state_nx_s     = FETCH_BUSY;
                end else begin
                    state_nx_s     = IDLE;
                end
            end
            DATA_BUSY, FETCH_BUSY: begin
                // A ready on the final watchdog cycle still completes normally.
                if (bus.mem_ready) begin
                    mem_req_nx_s = 1'b0;
                    mem_we_nx_s  = 1'b0;
                    if (state_r == DATA_BUSY) begin
                        if (!mem_we_r) begin
                            dm_rdata_nx_s = bus.mem_rdata;
                        end else begin
                            dm_rdata_nx_s = dm_rdata_r;
                        end
                        dm_done_nx_s = 1'b1;
                        state_nx_s   = DATA_DONE;
                    end else begin
                        if_instr_nx_s = bus.mem_rdata;
                        if_done_nx_s  = 1'b1;
                        state_nx_s    = FETCH_DONE;
                    end
                end else if (wdog_expire_s) begin
                    mem_req_nx_s = 1'b0;
                    mem_we_nx_s  = 1'b0;
                    bus_err_nx_s = 1'b1;
                    if (state_r == DATA_BUSY) begin
                        dm_rdata_nx_s = {DATA_W{1'b0}};
                        dm_done_nx_s  = 1'b1;
                        state_nx_s    = DATA_DONE;
                    end else begin
                        if_instr_nx_s = {DATA_W{1'b0}};
                        if_done_nx_s  = 1'b1;
                        state_nx_s    = FETCH_DONE;
                    end
                end else begin
                    wdog_nx_s = wdog_r + 16'd1;
                end
            end
            DATA_DONE, FETCH_DONE: begin
                state_nx_s = IDLE;
            end
            default: begin
                mem_req_nx_s = 1'b0;
                mem_we_nx_s  = 1'b0;
                state_nx_s   = IDLE;
            end
        endcase
    end

    // State and registered-output update with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= {DATA_W{1'b0}};
            if_instr_r  <= {DATA_W{1'b0}};
            dm_rdata_r  <= {DATA_W{1'b0}};
            if_done_r   <= 1'b0;
            dm_done_r   <= 1'b0;
            bus_err_r   <= 1'b0;
            wdog_r      <= 16'd0;
        end else begin
            state_r     <= state_nx_s;
            mem_req_r   <= mem_req_nx_s;
            mem_we_r    <= mem_we_nx_s;
            mem_addr_r  <= mem_addr_nx_s;
            mem_wdata_r <= mem_wdata_nx_s;
            if_instr_r  <= if_instr_nx_s;
            dm_rdata_r  <= dm_rdata_nx_s;
            if_done_r   <= if_done_nx_s;
            dm_done_r   <= dm_done_nx_s;
            bus_err_r   <= bus_err_nx_s;
            wdog_r      <= wdog_nx_s;
        end
    end

    // Stalls release in the done cycle so the pipeline advances at its end.
    always_comb begin
        stall_mem_s = (bus.dm_read | bus.dm_write) & ~dm_done_r;
        stall_if_s  = (bus.if_req & ~if_done_r) | stall_mem_s;
    end

    assign bus.mem_req   = mem_req_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign bus.if_instr  = if_instr_r;
    assign bus.dm_rdata  = dm_rdata_r;
    assign bus.if_done   = if_done_r;
    assign bus.dm_done   = dm_done_r;
    assign bus.bus_err   = bus_err_r;
    assign bus.stall_mem = stall_mem_s;
    assign bus.stall_if  = stall_if_s;
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: fetch, load+fetch ordering, store,
// read/write collision, watchdog abort and reset during an access.
module tb_unified_mem_arbiter;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    unified_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

    unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus_if.if_req    = 1'b0;
        bus_if.if_addr   = 32'h0;
        bus_if.dm_read   = 1'b0;
        bus_if.dm_write  = 1'b0;
        bus_if.dm_addr   = 32'h0;
        bus_if.dm_wdata  = 32'h0;
        bus_if.mem_ready = 1'b0;
        bus_if.mem_rdata = 32'h0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if ({bus_if.mem_req, bus_if.mem_we, bus_if.if_done, bus_if.dm_done, bus_if.bus_err,
             bus_if.stall_if, bus_if.stall_mem} !== 7'b0) begin
            errors++;
            $display("FAIL reset_flags got %b expected 0000000", {bus_if.mem_req, bus_if.mem_we,
                     bus_if.if_done, bus_if.dm_done, bus_if.bus_err, bus_if.stall_if, bus_if.stall_mem});
        end
        checks++;
        if ({bus_if.mem_addr, bus_if.mem_wdata, bus_if.if_instr, bus_if.dm_rdata} !== 128'h0) begin
            errors++;
            $display("FAIL reset_data got %h expected 0", {bus_if.mem_addr, bus_if.mem_wdata,
                     bus_if.if_instr, bus_if.dm_rdata});
        end
    endtask

    task automatic test_fetch_only();
        bus_if.if_req  = 1'b1;
        bus_if.if_addr = 32'h0000_0040;
        tick();
        checks++;
        if ({bus_if.mem_req, bus_if.mem_we, bus_if.stall_if} !== 3'b101 || bus_if.mem_addr !== 32'h40) begin
            errors++;
            $display("FAIL fetch_issue got req/we/stall=%b addr=%h expected 101 addr=00000040",
                     {bus_if.mem_req, bus_if.mem_we, bus_if.stall_if}, bus_if.mem_addr);
        end
        tick();
        checks++;
        if ({bus_if.mem_req, bus_if.stall_if, bus_if.if_done} !== 3'b110) begin
            errors++;
            $display("FAIL fetch_wait got req/stall/done=%b expected 110",
                     {bus_if.mem_req, bus_if.stall_if, bus_if.if_done});
        end
        bus_if.mem_ready = 1'b1;
        bus_if.mem_rdata = 32'h2008_0005;
        tick();
        bus_if.mem_ready = 1'b0;
        #1;
        checks++;
        if ({bus_if.if_done, bus_if.mem_req, bus_if.stall_if} !== 3'b100 || bus_if.if_instr !== 32'h2008_0005) begin
            errors++;
            $display("FAIL fetch_done got done/req/stall=%b instr=%h expected 100 instr=20080005",
                     {bus_if.if_done, bus_if.mem_req, bus_if.stall_if}, bus_if.if_instr);
        end
        bus_if.if_req = 1'b0;
        tick();
        tick();
        checks++;
        if ({bus_if.if_done, bus_if.mem_req} !== 2'b00) begin
            errors++;
            $display("FAIL fetch_after got done/req=%b expected 00", {bus_if.if_done, bus_if.mem_req});
        end
    endtask

    task automatic test_load_and_fetch();
        bus_if.dm_read = 1'b1;
        bus_if.dm_addr = 32'h100;
        bus_if.if_req  = 1'b1;
        bus_if.if_addr = 32'h44;
        #1;
        checks++;
        if ({bus_if.stall_mem, bus_if.stall_if} !== 2'b11) begin
            errors++;
            $display("FAIL lf_stall_pre got %b expected 11", {bus_if.stall_mem, bus_if.stall_if});
        end
        tick();
        checks++;
        if ({bus_if.mem_req, bus_if.mem_we} !== 2'b10 || bus_if.mem_addr !== 32'h100) begin
            errors++;
            $display("FAIL lf_data_first got req/we=%b addr=%h expected 10 addr=00000100",
                     {bus_if.mem_req, bus_if.mem_we}, bus_if.mem_addr);
        end
        bus_if.mem_ready = 1'b1;
        bus_if.mem_rdata = 32'hDEAD_BEEF;
        tick();
        bus_if.mem_ready = 1'b0;
        #1;
        checks++;
        if ({bus_if.dm_done, bus_if.mem_req, bus_if.stall_mem, bus_if.stall_if} !== 4'b1001 ||
            bus_if.dm_rdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL lf_data_done got done/req/smem/sif=%b rdata=%h expected 1001 rdata=deadbeef",
                     {bus_if.dm_done, bus_if.mem_req, bus_if.stall_mem, bus_if.stall_if}, bus_if.dm_rdata);
        end
        bus_if.dm_read = 1'b0;
        tick();
        checks++;
        if ({bus_if.mem_req, bus_if.dm_done} !== 2'b00) begin
            errors++;
            $display("FAIL lf_idle got req/done=%b expected 00", {bus_if.mem_req, bus_if.dm_done});
        end
        tick();
        checks++;
        if (bus_if.mem_req !== 1'b1 || bus_if.mem_addr !== 32'h44) begin
            errors++;
            $display("FAIL lf_fetch_issue got req=%b addr=%h expected 1 addr=00000044",
                     bus_if.mem_req, bus_if.mem_addr);
        end
        bus_if.mem_ready = 1'b1;
        bus_if.mem_rdata = 32'h0000_0013;
        tick();
        bus_if.mem_ready = 1'b0;
        checks++;
        if (bus_if.if_done !== 1'b1 || bus_if.if_instr !== 32'h13 || bus_if.dm_rdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL lf_fetch_done got done=%b instr=%h rdata=%h expected 1 00000013 deadbeef",
                     bus_if.if_done, bus_if.if_instr, bus_if.dm_rdata);
        end
        bus_if.if_req = 1'b0;
        tick();
    endtask

    task automatic test_store();
        bus_if.dm_write = 1'b1;
        bus_if.dm_addr  = 32'h200;
        bus_if.dm_wdata = 32'h1234_5678;
        tick();
        bus_if.dm_wdata = 32'hFFFF_FFFF;
        checks++;
        if ({bus_if.mem_req, bus_if.mem_we} !== 2'b11 || bus_if.mem_addr !== 32'h200 ||
            bus_if.mem_wdata !== 32'h1234_5678) begin
            errors++;
            $display("FAIL st_issue got req/we=%b addr=%h wdata=%h expected 11 00000200 12345678",
                     {bus_if.mem_req, bus_if.mem_we}, bus_if.mem_addr, bus_if.mem_wdata);
        end
        tick();
        checks++;
        if ({bus_if.mem_req, bus_if.mem_we} !== 2'b11 || bus_if.mem_wdata !== 32'h1234_5678) begin
            errors++;
            $display("FAIL st_hold got req/we=%b wdata=%h expected 11 12345678",
                     {bus_if.mem_req, bus_if.mem_we}, bus_if.mem_wdata);
        end
        bus_if.mem_ready = 1'b1;
        bus_if.mem_rdata = 32'hCAFE_F00D;
        tick();
        bus_if.mem_ready = 1'b0;
        checks++;
        if ({bus_if.dm_done, bus_if.mem_req} !== 2'b10 || bus_if.dm_rdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL st_done got done/req=%b rdata=%h expected 10 deadbeef",
                     {bus_if.dm_done, bus_if.mem_req}, bus_if.dm_rdata);
        end
        tick();
        checks++;
        if ({bus_if.dm_done, bus_if.mem_req} !== 2'b00) begin
            errors++;
            $display("FAIL st_no_reissue got done/req=%b expected 00", {bus_if.dm_done, bus_if.mem_req});
        end
        bus_if.dm_write = 1'b0;
        tick();
    endtask

    task automatic test_read_write_both();
        bus_if.dm_read  = 1'b1;
        bus_if.dm_write = 1'b1;
        bus_if.dm_addr  = 32'h300;
        bus_if.dm_wdata = 32'h0BAD_C0DE;
        tick();
        checks++;
        if ({bus_if.mem_req, bus_if.mem_we} !== 2'b11 || bus_if.mem_addr !== 32'h300) begin
            errors++;
            $display("FAIL rw_is_write got req/we=%b addr=%h expected 11 00000300",
                     {bus_if.mem_req, bus_if.mem_we}, bus_if.mem_addr);
        end
        bus_if.mem_ready = 1'b1;
        bus_if.mem_rdata = 32'h1111_1111;
        tick();
        bus_if.mem_ready = 1'b0;
        checks++;
        if (bus_if.dm_done !== 1'b1 || bus_if.dm_rdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL rw_done got done=%b rdata=%h expected 1 deadbeef", bus_if.dm_done, bus_if.dm_rdata);
        end
        bus_if.dm_read  = 1'b0;
        bus_if.dm_write = 1'b0;
        tick();
    endtask

    task automatic test_watchdog();
        bus_if.dm_read = 1'b1;
        bus_if.dm_addr = 32'h400;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (bus_if.mem_req !== 1'b1 || bus_if.dm_done !== 1'b0) begin
                errors++;
                $display("FAIL wd_req_cycle%0d got req/done=%b expected 10", i, {bus_if.mem_req, bus_if.dm_done});
            end
        end
        tick();
        checks++;
        if ({bus_if.mem_req, bus_if.dm_done, bus_if.bus_err} !== 3'b011 || bus_if.dm_rdata !== 32'h0) begin
            errors++;
            $display("FAIL wd_abort got req/done/err=%b rdata=%h expected 011 00000000",
                     {bus_if.mem_req, bus_if.dm_done, bus_if.bus_err}, bus_if.dm_rdata);
        end
        bus_if.dm_read = 1'b0;
        bus_if.if_req  = 1'b1;
        bus_if.if_addr = 32'h48;
        tick();
        tick();
        bus_if.mem_ready = 1'b1;
        bus_if.mem_rdata = 32'h0000_0073;
        tick();
        bus_if.mem_ready = 1'b0;
        bus_if.if_req    = 1'b0;
        checks++;
        if ({bus_if.if_done, bus_if.bus_err} !== 2'b11 || bus_if.if_instr !== 32'h73) begin
            errors++;
            $display("FAIL wd_sticky got done/err=%b instr=%h expected 11 00000073",
                     {bus_if.if_done, bus_if.bus_err}, bus_if.if_instr);
        end
        tick();
    endtask

    task automatic test_reset_mid_access();
        bus_if.if_req  = 1'b1;
        bus_if.if_addr = 32'h80;
        tick();
        checks++;
        if (bus_if.mem_req !== 1'b1 || bus_if.mem_addr !== 32'h80) begin
            errors++;
            $display("FAIL rm_busy got req=%b addr=%h expected 1 00000080", bus_if.mem_req, bus_if.mem_addr);
        end
        reset         = 1'b1;
        bus_if.if_req = 1'b0;
        tick();
        reset = 1'b0;
        checks++;
        if ({bus_if.mem_req, bus_if.mem_we, bus_if.if_done, bus_if.dm_done, bus_if.bus_err} !== 5'b0 ||
            {bus_if.mem_addr, bus_if.mem_wdata, bus_if.if_instr, bus_if.dm_rdata} !== 128'h0) begin
            errors++;
            $display("FAIL rm_cleared got flags=%b data=%h expected all zero",
                     {bus_if.mem_req, bus_if.mem_we, bus_if.if_done, bus_if.dm_done, bus_if.bus_err},
                     {bus_if.mem_addr, bus_if.mem_wdata, bus_if.if_instr, bus_if.dm_rdata});
        end
        bus_if.mem_ready = 1'b1;
        bus_if.mem_rdata = 32'h5555_5555;
        tick();
        bus_if.mem_ready = 1'b0;
        checks++;
        if ({bus_if.if_done, bus_if.mem_req} !== 2'b00 || bus_if.if_instr !== 32'h0) begin
            errors++;
            $display("FAIL rm_late_ready got done/req=%b instr=%h expected 00 00000000",
                     {bus_if.if_done, bus_if.mem_req}, bus_if.if_instr);
        end
        bus_if.if_req  = 1'b1;
        bus_if.if_addr = 32'h84;
        tick();
        checks++;
        if (bus_if.mem_req !== 1'b1 || bus_if.mem_addr !== 32'h84) begin
            errors++;
            $display("FAIL rm_fresh_issue got req=%b addr=%h expected 1 00000084", bus_if.mem_req, bus_if.mem_addr);
        end
        bus_if.mem_ready = 1'b1;
        bus_if.mem_rdata = 32'h00A0_0093;
        tick();
        bus_if.mem_ready = 1'b0;
        bus_if.if_req    = 1'b0;
        checks++;
        if (bus_if.if_done !== 1'b1 || bus_if.if_instr !== 32'h00A0_0093) begin
            errors++;
            $display("FAIL rm_fresh_done got done=%b instr=%h expected 1 00a00093", bus_if.if_done, bus_if.if_instr);
        end
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        test_reset();
        test_fetch_only();
        test_load_and_fetch();
        test_store();
        test_read_write_both();
        test_watchdog();
        test_reset_mid_access();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
